// File: rtl/iq_pkg.sv
// Shared issue-queue / ROB types: tag widths and the completion record.
package iq_pkg;

  localparam int unsigned PREG_W = 8;
  localparam int unsigned ROB_W  = 7;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] preg;
  } completion_t;

endpackage

// File: rtl/wakeup_fifo.sv
// Single-requester circular buffer of completion records with synchronous clear.
module wakeup_fifo
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clr,
  input  logic            i_push,
  input  completion_t     i_data,
  input  logic            i_pop,
  output completion_t     o_head,
  output logic [CntW-1:0] o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  completion_t     r_mem [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  // Storage array: payload only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (i_push && !i_clr) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/wakeup_arbiter.sv
// Completion-broadcast scheduler: per-requester FIFOs, round-robin pick, one
// registered wakeup/completion broadcast per cycle.
module wakeup_arbiter
  import iq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned CntW   = $clog2(NUM_REQ * DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*PREG_W-1:0] req_preg,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
  output logic                      executed,
  output logic [PREG_W-1:0]         executedReg,
  output logic [ROB_W-1:0]          completedRob,
  output logic [CntW-1:0]           pending_cnt
);

  localparam int unsigned PtrW     = $clog2(NUM_REQ);
  localparam int unsigned FifoCntW = $clog2(DEPTH + 1);

  completion_t         w_head  [NUM_REQ];
  logic [FifoCntW-1:0] w_count [NUM_REQ];
  logic [NUM_REQ-1:0]  w_ready;
  logic [NUM_REQ-1:0]  w_push;
  logic [NUM_REQ-1:0]  w_pop;
  logic [NUM_REQ-1:0]  w_nonempty;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_grant;
  logic [PtrW-1:0]      w_off;
  logic [PtrW:0]        w_sum;
  logic [PtrW-1:0]      w_gnt_idx;
  logic [PtrW-1:0]      w_next_rr;
  logic [CntW-1:0]      w_push_cnt;

  logic [PtrW-1:0]   r_rr_ptr;
  logic              r_executed;
  logic [PREG_W-1:0] r_exec_reg;
  logic [ROB_W-1:0]  r_comp_rob;
  logic [CntW-1:0]   r_pending;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    completion_t w_data;
    assign w_data.preg = req_preg[gi*PREG_W +: PREG_W];
    assign w_data.rob  = req_rob[gi*ROB_W +: ROB_W];

    wakeup_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (flush),
      .i_push  (w_push[gi]),
      .i_data  (w_data),
      .i_pop   (w_pop[gi]),
      .o_head  (w_head[gi]),
      .o_count (w_count[gi])
    );
  end

  // Ready depends only on occupancy and flush: a full FIFO popped this cycle stays not-ready.
  always_comb begin
    w_ready    = '0;
    w_nonempty = '0;
    w_push_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_nonempty[i] = (w_count[i] != '0);
      w_ready[i]    = (w_count[i] < FifoCntW'(DEPTH)) & ~flush;
    end
    w_push = req_valid & w_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_push_cnt = w_push_cnt + CntW'(w_push[i]);
    end
  end

  assign req_ready = w_ready;

  // Round-robin pick: rotate so rr_ptr is bit 0, find first, rotate the index back.
  always_comb begin
    w_dbl   = {w_nonempty, w_nonempty};
    w_rot   = w_dbl[r_rr_ptr +: NUM_REQ];
    w_grant = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_grant && w_rot[k]) begin
        w_grant = 1'b1;
        w_off   = PtrW'(k);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (PtrW + 1)'(NUM_REQ)) begin
      w_sum = w_sum - (PtrW + 1)'(NUM_REQ);
    end
    w_gnt_idx = w_sum[PtrW-1:0];
    w_next_rr = (w_gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    w_pop     = '0;
    if (w_grant && !flush) begin
      w_pop[w_gnt_idx] = 1'b1;
    end
  end

  // Broadcast registers, round-robin pointer and occupancy total; flush overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr   <= '0;
      r_executed <= 1'b0;
      r_exec_reg <= '0;
      r_comp_rob <= '0;
      r_pending  <= '0;
    end else if (flush) begin
      r_rr_ptr   <= '0;
      r_executed <= 1'b0;
      r_pending  <= '0;
    end else begin
      r_executed <= w_grant;
      if (w_grant) begin
        r_exec_reg <= w_head[w_gnt_idx].preg;
        r_comp_rob <= w_head[w_gnt_idx].rob;
        r_rr_ptr   <= w_next_rr;
      end
      r_pending <= r_pending + w_push_cnt - CntW'(w_grant);
    end
  end

  assign executed     = r_executed;
  assign executedReg  = r_exec_reg;
  assign completedRob = r_comp_rob;
  assign pending_cnt  = r_pending;

endmodule

// File: tb/tb_wakeup_arbiter.sv
// Directed + random bench for wakeup_arbiter against a queue-based reference model.
module tb_wakeup_arbiter;
  import iq_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 2;
  localparam int CntW    = $clog2(NUM_REQ * DEPTH + 1);

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*PREG_W-1:0] req_preg;
  logic [NUM_REQ*ROB_W-1:0]  req_rob;
  logic                      executed;
  logic [PREG_W-1:0]         executedReg;
  logic [ROB_W-1:0]          completedRob;
  logic [CntW-1:0]           pending_cnt;

  wakeup_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_preg     (req_preg),
    .req_rob      (req_rob),
    .executed     (executed),
    .executedReg  (executedReg),
    .completedRob (completedRob),
    .pending_cnt  (pending_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per requester plus round-robin pointer and broadcast state.
  completion_t       mq [NUM_REQ][$];
  int                m_rr = 0;
  logic              m_exec = 1'b0;
  logic [PREG_W-1:0] m_preg = '0;
  logic [ROB_W-1:0]  m_rob = '0;
  int                max_pend = 0;

  logic [PREG_W-1:0] p_preg [NUM_REQ];
  logic [ROB_W-1:0]  p_rob  [NUM_REQ];
  int                seq = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Payload with the requester index in rob[6:5] so grants are identifiable.
  task automatic set_pay(input int i, input logic [PREG_W-1:0] preg);
    logic [4:0] s;
    s = 5'(seq);
    seq++;
    p_preg[i] = preg;
    p_rob[i]  = {2'(i), s};
  endtask

  task automatic rand_pay();
    for (int i = 0; i < NUM_REQ; i++) set_pay(i, PREG_W'($urandom_range(0, 255)));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
    m_rr = 0;
  endtask

  // One clock: drive at negedge, check ready, advance model, check outputs after posedge.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic fl);
    logic [NUM_REQ-1:0] exp_rdy;
    int                 g;
    int                 tot;
    completion_t        c;
    @(negedge clk);
    req_valid = v;
    flush     = fl;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_preg[i*PREG_W +: PREG_W] = p_preg[i];
      req_rob[i*ROB_W +: ROB_W]    = p_rob[i];
      exp_rdy[i] = (mq[i].size() < DEPTH) && !fl;
    end
    #1 chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (m_rr + k) % NUM_REQ;
      if (g < 0 && mq[idx].size() > 0) g = idx;
    end
    if (fl) begin
      model_clear();
      m_exec = 1'b0;
    end else begin
      if (g >= 0) begin
        c      = mq[g].pop_front();
        m_exec = 1'b1;
        m_preg = c.preg;
        m_rob  = c.rob;
        m_rr   = (g + 1) % NUM_REQ;
      end else begin
        m_exec = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (v[i] && exp_rdy[i]) begin
          c.preg = p_preg[i];
          c.rob  = p_rob[i];
          mq[i].push_back(c);
        end
      end
    end
    tot = 0;
    for (int i = 0; i < NUM_REQ; i++) tot += mq[i].size();
    @(posedge clk);
    #1;
    chk("executed", 32'(executed), 32'(m_exec));
    chk("executedReg", 32'(executedReg), 32'(m_preg));
    chk("completedRob", 32'(completedRob), 32'(m_rob));
    chk("pending_cnt", 32'(pending_cnt), 32'(tot));
    if (int'(pending_cnt) > max_pend) max_pend = int'(pending_cnt);
  endtask

  initial begin
    int exp_req;
    reset     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_preg  = '0;
    req_rob   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      p_preg[i] = '0;
      p_rob[i]  = '0;
    end

    // Reset state
    #3;
    chk("rst_executed", 32'(executed), 32'd0);
    chk("rst_tag", 32'(executedReg), 32'd0);
    chk("rst_rob", 32'(completedRob), 32'd0);
    chk("rst_pending", 32'(pending_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_ready", 32'(req_ready), 32'hF);

    // Simultaneous: pregs 0x10..0x13 from rr_ptr 0 broadcast in index order
    for (int i = 0; i < NUM_REQ; i++) set_pay(i, PREG_W'(8'h10 + i));
    step(4'b1111, 1'b0);
    for (int k = 0; k < NUM_REQ; k++) begin
      step(4'b0000, 1'b0);
      chk("sim_exec", 32'(executed), 32'd1);
      chk("sim_order", 32'(executedReg), 32'(8'h10 + k));
    end
    step(4'b0000, 1'b0);
    chk("sim_pending", 32'(pending_cnt), 32'd0);

    // Single report: one-cycle broadcast two edges after presentation
    set_pay(0, 8'h15);
    p_rob[0] = 7'h03;
    step(4'b0001, 1'b0);
    chk("single_early", 32'(executed), 32'd0);
    step(4'b0000, 1'b0);
    chk("single_exec", 32'(executed), 32'd1);
    chk("single_tag", 32'(executedReg), 32'h15);
    chk("single_rob", 32'(completedRob), 32'h03);
    step(4'b0000, 1'b0);
    chk("single_drop", 32'(executed), 32'd0);

    // Fairness: requesters 1 and 3 always valid must alternate
    exp_req = 1;
    for (int k = 0; k < 10; k++) begin
      rand_pay();
      step(4'b1010, 1'b0);
      if (k > 0) begin
        chk("fair_exec", 32'(executed), 32'd1);
        chk("fair_req", 32'(completedRob[6:5]), 32'(exp_req));
        exp_req = (exp_req == 1) ? 3 : 1;
      end
    end
    for (int k = 0; k < 6; k++) step(4'b0000, 1'b0);

    // Backpressure: all valid for six cycles, then drain
    max_pend = 0;
    for (int k = 0; k < 6; k++) begin
      rand_pay();
      step(4'b1111, 1'b0);
    end
    for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);
    chk("bp_max_le8", 32'(max_pend <= NUM_REQ * DEPTH), 32'd1);
    chk("bp_drained", 32'(pending_cnt), 32'd0);

    // Flush with five buffered; the report offered during flush is dropped
    rand_pay();
    step(4'b1111, 1'b0);
    rand_pay();
    step(4'b0011, 1'b0);
    chk("fl_pre_pending", 32'(pending_cnt), 32'd5);
    set_pay(2, 8'hEE);
    step(4'b0100, 1'b1);
    chk("fl_pending", 32'(pending_cnt), 32'd0);
    chk("fl_exec", 32'(executed), 32'd0);
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b0);
    rand_pay();
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);
    chk("fl_rr_zero", 32'(completedRob[6:5]), 32'd0);
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b0);

    // Random traffic with occasional flush
    for (int k = 0; k < 200; k++) begin
      rand_pay();
      step(NUM_REQ'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
    end
    for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);

    // Asynchronous reset mid-burst with three buffered
    rand_pay();
    step(4'b0111, 1'b0);
    rand_pay();
    step(4'b1000, 1'b0);
    chk("mr_pending", 32'(pending_cnt), 32'd3);
    chk("mr_exec", 32'(executed), 32'd1);
    #2;
    reset     = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    #1;
    chk("mr_rst_exec", 32'(executed), 32'd0);
    chk("mr_rst_tag", 32'(executedReg), 32'd0);
    chk("mr_rst_rob", 32'(completedRob), 32'd0);
    chk("mr_rst_pending", 32'(pending_cnt), 32'd0);
    model_clear();
    m_exec = 1'b0;
    m_preg = '0;
    m_rob  = '0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mr_ready", 32'(req_ready), 32'hF);
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wakeup_arbiter.md
# wakeup_arbiter

Completion-broadcast scheduler for the 4-wide issue queue. The IQ issues up to four instructions per cycle but accepts only one `executed`/`executedReg` wakeup tag per cycle. This block buffers completion reports from NUM_REQ functional units, arbitrates round-robin, and drives a single registered broadcast each cycle. The broadcast goes to the IQ wakeup port (`executedReg`) and to the ROB completion port (`completedRob`).

## Interface
- NUM_REQ, 4, number of functional-unit requesters
- DEPTH, 2, per-requester buffer entries (power of 2, ≥2)
- PREG_W, 8, physical register tag width
- ROB_W, 7, ROB index width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all buffered completions
- req_valid  in  NUM_REQ  completion report valid, per requester
- req_ready  out  NUM_REQ  requester buffer can accept
- req_preg  in  NUM_REQ×PREG_W  destination physical register per requester
- req_rob  in  NUM_REQ×ROB_W  ROB index per requester
- executed  out  1  broadcast valid (to IQ `executed`)
- executedReg  out  PREG_W  broadcast tag (to IQ `executedReg`)
- completedRob  out  ROB_W  ROB index of the broadcast entry
- pending_cnt  out  $clog2(NUM_REQ*DEPTH+1)  total buffered entries

## Operation
- Per-requester FIFO of {rob, preg}. Push on `req_valid[i] & req_ready[i]`.
- `req_ready[i] = (count[i] < DEPTH) & ~flush`. Depends only on state and flush, never on the same-cycle grant. A full FIFO being popped this cycle is still not ready; there is no pass-through.
- Arbiter: among non-empty FIFOs, grant the first index at or after `rr_ptr`, searching cyclically. At most one grant per cycle. The granted FIFO pops its head.
- After a grant to i: `rr_ptr <= (i+1) mod NUM_REQ`. With no grant, `rr_ptr` holds.
- Output registers load the granted head: `executed <= 1`, plus its preg/rob. With no grant: `executed <= 0`, and the tag/rob fields hold their previous value.
- FIFO read/write pointers wrap modulo DEPTH. Each FIFO tracks its count with DEPTH+1 states (0..DEPTH).
- `pending_cnt` = sum of FIFO counts (registered state). Updated each edge by pushes minus pops.
- Order is preserved per requester. No ordering is guaranteed across requesters. No deduplication: identical pregs from two requesters are broadcast twice.
- flush (highest priority):
  - all FIFOs are emptied; pushes and the pop are suppressed that cycle;
  - `executed <= 0`;
  - `rr_ptr <= 0`;
  - `pending_cnt <= 0`.
- Reset (asynchronous, any time including mid-burst): FIFOs empty, `rr_ptr = 0`, `executed = 0`, `executedReg = 0`, `completedRob = 0`, `pending_cnt = 0`. `req_ready` becomes all-ones once reset deasserts (flush low).

## Timing
- Latency: a report sampled at edge k appears on `executed`/`executedReg`/`completedRob` after edge k+1, assuming it wins arbitration. There is no same-cycle bypass.
- `executed` is high for exactly one cycle per granted entry.
- Throughput: one broadcast per cycle, sustained whenever `pending_cnt > 0`.
- Fairness: a non-empty requester is granted within NUM_REQ cycles.
- Push and pop on the same FIFO in one cycle (count below DEPTH): count unchanged.
- All outputs are driven from flops except `req_ready`, which is combinational from count and flush.

## Structure
- Shared package `iq_pkg`:
  - `PREG_W`, `ROB_W`;
  - `typedef struct packed {logic [ROB_W-1:0] rob; logic [PREG_W-1:0] preg;} completion_t`.
  - The IQ and ROB use the same package.
- Sub-module `wakeup_fifo`: a single-requester circular buffer with push, pop, head, count, and synchronous clear. It is instantiated NUM_REQ times.
- The top level holds the round-robin priority logic (rotate, find-first, rotate back), the output registers, and `pending_cnt`.

## Test plan
- Reset: assert reset mid-stream with `pending_cnt=3` → all outputs 0 immediately, `req_ready=4'b1111` after release, no residual broadcasts.
- Single report: requester 0, preg 0x15, rob 0x03, accepted at edge 1 → after edge 2 `executed=1`, `executedReg=0x15`, `completedRob=0x03` for one cycle, then `executed=0`.
- Simultaneous: all four valid in one cycle, pregs 0x10–0x13, `rr_ptr=0` → broadcasts 0x10, 0x11, 0x12, 0x13 on four consecutive cycles; final `rr_ptr=0`, `pending_cnt=0`.
- Fairness: requesters 1 and 3 valid every cycle → grants alternate 1, 3, 1, 3; requester 1 never gets two grants in a row.
- Backpressure: all four valid continuously for 6 cycles with DEPTH=2 → each `req_ready[i]` drops when its count reaches 2; `pending_cnt` never exceeds 8; every accepted entry is broadcast exactly once, in per-requester order.
- Flush: `pending_cnt=5`, pulse flush one cycle → next cycle `pending_cnt=0`, `executed=0`, `rr_ptr=0`; a report presented during flush is not accepted and never broadcast.
